// File: rtl/sm_debug_pkg.sv
// Shared command codes, state encodings and dump word bundle
// for the sm_cpu run/halt/step/dump debug controller.
package sm_debug_pkg;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_DUMP = 2'd3;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_RD   = 2'd1;
    localparam logic [1:0] PH_OUT  = 2'd2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } dump_word_t;

    function automatic logic [1:0] reset_state(input bit run);
        return run ? ST_RUN : ST_HALT;
    endfunction

endpackage

// File: rtl/sm_debug_dump.sv
// Register-dump walker: reads debug addresses 0..NREG-1 one at
// a time and presents each word on a valid/ready output stage.
module sm_debug_dump
    import sm_debug_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] reg_data_i,
    input  logic        dump_ready_i,
    output logic [4:0]  reg_addr_o,
    output logic        dump_valid_o,
    output logic [4:0]  dump_addr_o,
    output logic [31:0] dump_data_o,
    output logic        done_o
);

    localparam logic [4:0] LAST = 5'(NREG - 1);

    logic [1:0] ph_q, ph_d;
    logic [4:0] a_q, a_d;
    dump_word_t word_q, word_d;

    always_comb begin
        ph_d   = ph_q;
        a_d    = a_q;
        word_d = word_q;
        done_o = 1'b0;
        unique case (ph_q)
            PH_IDLE: begin
                if (start_i) begin
                    ph_d = PH_RD;
                    a_d  = '0;
                end
            end
            PH_RD: begin
                word_d = '{addr: a_q, data: reg_data_i};
                ph_d   = PH_OUT;
            end
            PH_OUT: begin
                if (dump_ready_i) begin
                    if (a_q == LAST) begin
                        ph_d   = PH_IDLE;
                        a_d    = '0;
                        done_o = 1'b1;
                    end else begin
                        ph_d = PH_RD;
                        a_d  = a_q + 5'd1;
                    end
                end
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= PH_IDLE;
            a_q    <= '0;
            word_q <= '0;
        end else begin
            ph_q   <= ph_d;
            a_q    <= a_d;
            word_q <= word_d;
        end
    end

    // a_q rests at 0 outside a dump, so the core shows its PC
    assign reg_addr_o   = a_q;
    assign dump_valid_o = (ph_q == PH_OUT);
    assign dump_addr_o  = word_q.addr;
    assign dump_data_o  = word_q.data;

endmodule

// File: rtl/sm_debug_ctrl.sv
// Run/halt/step controller with one PC breakpoint; gates sm_cpu
// through cpu_en and hands the debug port to the dump walker.
module sm_debug_ctrl
    import sm_debug_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int CNT_W        = 8,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
    output logic             cpu_en,
    output logic [4:0]       regAddr,
    input  logic [31:0]      regData,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_addr,
    output logic [31:0]      dump_data,
    output logic             halted,
    output logic             bp_hit,
    output logic             cmd_err
);

    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skip_q, skip_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;
    logic             run, brk, fire;
    logic             dump_start, dump_done;

    assign cmd_ready  = (st_q == ST_HALT) | (st_q == ST_RUN);
    assign fire       = cmd_valid & cmd_ready;
    assign halted     = (st_q == ST_HALT);
    assign run        = (st_q == ST_RUN) | (st_q == ST_STEP);
    assign brk        = run & bp_en & (regData == bp_pc) & ~skip_q;
    assign cpu_en     = run & ~brk;
    assign dump_start = fire & halted & (cmd_op == OP_DUMP);
    assign bp_hit     = hit_q;
    assign cmd_err    = err_q;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        skip_d = skip_q;
        hit_d  = hit_q;
        err_d  = 1'b0;
        if (cpu_en) skip_d = 1'b0;
        unique case (st_q)
            ST_HALT: begin
                if (fire) begin
                    unique case (cmd_op)
                        OP_RUN: begin
                            st_d   = ST_RUN;
                            skip_d = 1'b1;
                            hit_d  = 1'b0;
                        end
                        OP_STEP: begin
                            st_d   = ST_STEP;
                            skip_d = 1'b1;
                            hit_d  = 1'b0;
                            cnt_d  = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
                        end
                        OP_DUMP: st_d = ST_DUMP;
                        OP_HALT: st_d = ST_HALT;
                        default: st_d = ST_HALT;
                    endcase
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (cmd_op == OP_HALT) st_d = ST_HALT;
                    else err_d = 1'b1;
                end
                if (brk) begin
                    st_d  = ST_HALT;
                    hit_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (brk) begin
                    st_d  = ST_HALT;
                    hit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) st_d = ST_HALT;
                end
            end
            ST_DUMP: begin
                if (dump_done) st_d = ST_HALT;
            end
            default: st_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= reset_state(RUN_ON_RESET);
            cnt_q  <= '0;
            skip_q <= 1'b1;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            skip_q <= skip_d;
            hit_q  <= hit_d;
            err_q  <= err_d;
        end
    end

    sm_debug_dump #(
        .NREG(NREG)
    ) u_dump (
        .clk         (clk),
        .rst         (rst),
        .start_i     (dump_start),
        .reg_data_i  (regData),
        .dump_ready_i(dump_ready),
        .reg_addr_o  (regAddr),
        .dump_valid_o(dump_valid),
        .dump_addr_o (dump_addr),
        .dump_data_o (dump_data),
        .done_o      (dump_done)
    );

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Bench for sm_debug_ctrl: a toy core (PC counter + register file)
// drives regData; step/breakpoint/dump outcomes come from a model.
module tb_sm_debug_ctrl;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_arg = 8'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = 32'd0;
    logic        cpu_en;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        halted;
    logic        bp_hit;
    logic        cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pc;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd1;
    end

    assign regData = (regAddr == 5'd0) ? pc : rf[regAddr];

    sm_debug_ctrl #(
        .NREG(32),
        .CNT_W(8),
        .RUN_ON_RESET(1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .bp_en     (bp_en),
        .bp_pc     (bp_pc),
        .cpu_en    (cpu_en),
        .regAddr   (regAddr),
        .regData   (regData),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .cmd_err   (cmd_err)
    );

    typedef struct {
        logic [7:0] arg;
        bit         bpen;
        int         off;
        int         exp_delta;
        bit         exp_hit;
    } step_vec_t;

    step_vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the next negedge.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg,
                            output logic err);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        err       = cmd_err;
    endtask

    task automatic wait_halt(input string name, output int en_cnt);
        int g;
        en_cnt = 0;
        g = 0;
        while (!halted && g < 2000) begin
            if (cpu_en) en_cnt++;
            @(negedge clk);
            g++;
        end
        chk({name, "_halt_timeout"}, 32'(halted), 32'd1);
    endtask

    task automatic do_step(input logic [7:0] arg, input bit bpen,
                           input int off, output int delta,
                           output logic hit, output int en_cnt);
        logic [31:0] pc0;
        logic err;
        pc0   = pc;
        bp_en = bpen;
        bp_pc = pc0 + 32'(off);
        send_cmd(OP_STEP, arg, err);
        wait_halt("step", en_cnt);
        delta = int'(pc - pc0);
        hit   = bp_hit;
        bp_en = 1'b0;
    endtask

    // Random ready (mode 1) or alternating 1/0 ready (mode 0).
    task automatic do_dump(input bit mode);
        logic [31:0] exp_q [$];
        logic [31:0] held_d;
        logic [4:0]  held_a;
        bit          pend;
        bit          tog;
        int          idx;
        int          g;
        int          en_bad;
        logic        err;
        for (int i = 0; i < 32; i++)
            exp_q.push_back((i == 0) ? pc : rf[i]);
        send_cmd(OP_DUMP, 8'd0, err);
        idx = 0; g = 0; pend = 0; tog = 1; en_bad = 0;
        held_d = '0; held_a = '0;
        while (idx < 32 && g < 1000) begin
            dump_ready = mode ? 1'($urandom_range(1, 0)) : tog;
            tog = ~tog;
            if (cpu_en) en_bad++;
            if (dump_valid && pend) begin
                chk("dump_hold_addr", 32'(dump_addr), 32'(held_a));
                chk("dump_hold_data", dump_data, held_d);
            end
            pend = 0;
            if (dump_valid && dump_ready) begin
                chk("dump_addr", 32'(dump_addr), 32'(idx));
                chk("dump_data", dump_data, exp_q[idx]);
                idx++;
            end else if (dump_valid) begin
                pend   = 1;
                held_a = dump_addr;
                held_d = dump_data;
            end
            @(negedge clk);
            g++;
        end
        dump_ready = 1'b0;
        chk("dump_words", 32'(idx), 32'd32);
        chk("dump_cpu_en", 32'(en_bad), 32'd0);
        chk("dump_halted", 32'(halted), 32'd1);
        chk("dump_valid_end", 32'(dump_valid), 32'd0);
        chk("dump_regaddr_end", 32'(regAddr), 32'd0);
    endtask

    initial begin
        int          delta;
        int          en_cnt;
        int          n;
        int          off;
        int          ed;
        bit          eh;
        bit          bpen;
        logic        hit;
        logic        err;
        logic [7:0]  arg;
        logic [31:0] pc_hold;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;

        tv[0] = '{8'd3,   1'b0, 0, 3, 1'b0};
        tv[1] = '{8'd0,   1'b0, 0, 1, 1'b0};
        tv[2] = '{8'd5,   1'b1, 2, 2, 1'b1};
        tv[3] = '{8'd4,   1'b1, 0, 4, 1'b0};
        tv[4] = '{8'd4,   1'b1, 4, 4, 1'b0};
        tv[5] = '{8'd1,   1'b1, 1, 1, 1'b0};
        tv[6] = '{8'd255, 1'b1, 7, 7, 1'b1};
        tv[7] = '{8'd6,   1'b1, 5, 5, 1'b1};

        // Reset held 4 cycles
        repeat (4) @(negedge clk);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_regaddr", 32'(regAddr), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // HALT while halted is a silent no-op
        send_cmd(OP_HALT, 8'd0, err);
        chk("halt_in_halt_err", 32'(err), 32'd0);
        chk("halt_in_halt", 32'(halted), 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_step(tv[i].arg, tv[i].bpen, tv[i].off, delta, hit, en_cnt);
            chk($sformatf("tv%0d_pc_delta", i), 32'(delta),
                32'(tv[i].exp_delta));
            chk($sformatf("tv%0d_bp_hit", i), 32'(hit), 32'(tv[i].exp_hit));
            chk($sformatf("tv%0d_en_cycles", i), 32'(en_cnt),
                32'(tv[i].exp_delta));
        end

        // Breakpoint at PC 5 from PC 0, then resume past it
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bp_en = 1'b1;
        bp_pc = 32'd5;
        send_cmd(OP_RUN, 8'd0, err);
        wait_halt("bp_run", en_cnt);
        chk("bp_stop_pc", pc, 32'd5);
        chk("bp_stop_hit", 32'(bp_hit), 32'd1);
        chk("bp_stop_en", 32'(en_cnt), 32'd5);
        send_cmd(OP_RUN, 8'd0, err);
        chk("bp_resume_hit", 32'(bp_hit), 32'd0);
        repeat (10) @(negedge clk);
        chk("bp_resume_past", 32'(pc > 32'd5), 32'd1);
        chk("bp_resume_running", 32'(halted), 32'd0);

        // Illegal commands while running
        send_cmd(OP_STEP, 8'd2, err);
        chk("run_step_err", 32'(err), 32'd1);
        send_cmd(OP_DUMP, 8'd0, err);
        chk("run_dump_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("run_err_pulse", 32'(cmd_err), 32'd0);
        chk("run_still_en", 32'(cpu_en), 32'd1);
        chk("run_still_running", 32'(halted), 32'd0);
        send_cmd(OP_HALT, 8'd0, err);
        chk("run_halt_err", 32'(err), 32'd0);
        chk("run_halted", 32'(halted), 32'd1);
        pc_hold = pc;
        repeat (3) @(negedge clk);
        chk("halt_pc_frozen", pc, pc_hold);
        bp_en = 1'b0;

        do_dump(1'b0);
        do_dump(1'b1);

        // Randomized steps against the breakpoint window model
        for (int k = 0; k < 25; k++) begin
            arg  = 8'($urandom_range(20, 0));
            bpen = 1'($urandom_range(1, 0));
            off  = int'($urandom_range(24, 0));
            n    = (arg == 8'd0) ? 1 : int'(arg);
            if (bpen && off >= 1 && off <= n - 1) begin
                ed = off;
                eh = 1'b1;
            end else begin
                ed = n;
                eh = 1'b0;
            end
            do_step(arg, bpen, off, delta, hit, en_cnt);
            chk($sformatf("rnd%0d_delta", k), 32'(delta), 32'(ed));
            chk($sformatf("rnd%0d_hit", k), 32'(hit), 32'(eh));
        end

        // Reset in the middle of a dump
        dump_ready = 1'b1;
        send_cmd(OP_DUMP, 8'd0, err);
        n = 0;
        while (!(dump_valid && dump_addr == 5'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_dump_reach10", 32'(dump_addr), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dump_ready = 1'b0;
        chk("rst_dump_valid0", 32'(dump_valid), 32'd0);
        chk("rst_dump_cpu_en0", 32'(cpu_en), 32'd0);
        chk("rst_dump_halted", 32'(halted), 32'd1);
        chk("rst_dump_regaddr", 32'(regAddr), 32'd0);

        // Reset in the middle of a step
        send_cmd(OP_STEP, 8'd50, err);
        repeat (5) @(negedge clk);
        chk("mid_step_en", 32'(cpu_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_step_cpu_en0", 32'(cpu_en), 32'd0);
        chk("rst_step_halted", 32'(halted), 32'd1);
        repeat (2) @(negedge clk);
        chk("rst_step_stays", 32'(cpu_en), 32'd0);
        chk("rst_step_pc", pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
